// File: rtl/apb_master_ctrl.sv
// APB3/APB4 initiator: takes one command over a valid/ready port, runs a single
// SETUP/ACCESS transfer with an optional ACCESS timeout, returns data/status on a response port.
module apb_master_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                  pclk,
    input  logic                  prest,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_strb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_W-1:0]     paddr,
    output logic [DATA_W-1:0]     pwdata,
    output logic [DATA_W/8-1:0]   pstrb,
    input  logic [DATA_W-1:0]     prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  wait_cnt;
    logic              timeout_hit;

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never depends on ready, and a raised valid holds its payload until taken.

    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge pclk) begin
        if (prest) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (pready || timeout_hit) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == IDLE) && !prest;
        psel      = (state == SETUP) || (state == ACCESS);
        penable   = (state == ACCESS);
        rsp_valid = (state == RESP);
    end

    // APB request fields are captured at accept and held for the whole transfer.
    always_ff @(posedge pclk) begin
        if (prest) begin
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            pstrb     <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        pwrite <= cmd_write;
                        paddr  <= cmd_addr;
                        pwdata <= cmd_wdata;
                        pstrb  <= cmd_write ? cmd_strb : {STRB_W{1'b0}};
                    end
                end
                ACCESS: begin
                    if (pready) begin
                        rsp_rdata <= pwrite ? {DATA_W{1'b0}} : prdata;
                        rsp_err   <= pslverr;
                    end else if (timeout_hit) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                    end else if (wait_cnt != {CNT_W{1'b1}}) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        wait_cnt  <= '0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: directed scenarios plus randomized transfers checked
// against a transaction-level model of the expected response.
module tb_apb_master_ctrl;

    localparam int TO = 8;

    logic        pclk = 1'b0;
    logic        prest = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_strb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata = '0;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    // observations from the last transfer
    logic        obs_accept_ok, obs_setup_ok, obs_stable, obs_hold_stable, obs_done_ok;
    logic        obs_pwrite, obs_psel_at_rsp, obs_rsp_valid, obs_err, obs_cmd_ready_rsp;
    logic [31:0] obs_paddr, obs_pwdata, obs_rdata;
    logic [3:0]  obs_pstrb;
    int          obs_access, obs_accept_cyc;

    apb_master_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .pclk(pclk), .prest(prest),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    // clock / reset
    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // transaction-level expectation: slave raises pready after 'waits' low cycles
    function automatic void model(input logic w, input int waits, input logic [31:0] rd,
                                  input logic se, output int acc, output logic [31:0] erd,
                                  output logic eerr);
        if (waits >= TO) begin
            acc = TO; erd = '0; eerr = 1'b1;
        end else begin
            acc = waits + 1; erd = w ? 32'h0 : rd; eerr = se;
        end
    endfunction

    // driver: issues one command, plays the APB slave, consumes the response
    task automatic run_xfer(input logic w, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] s, input int waits, input logic [31:0] rd,
                            input logic se, input int hold);
        int guard;
        cmd_write = w; cmd_addr = a; cmd_wdata = wd; cmd_strb = s;
        cmd_valid = 1'b1; rsp_ready = 1'b0; pready = 1'b0;
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        obs_accept_ok = (cmd_ready === 1'b1);
        obs_accept_cyc = cyc;
        tick();
        cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom;
        cmd_strb = 4'($urandom_range(0, 15)); cmd_write = 1'($urandom_range(0, 1));
        obs_setup_ok = (psel === 1'b1 && penable === 1'b0);
        obs_paddr = paddr; obs_pwrite = pwrite; obs_pwdata = pwdata; obs_pstrb = pstrb;
        obs_stable = 1'b1;
        tick();
        obs_access = 0;
        while (psel === 1'b1 && penable === 1'b1 && obs_access < 40) begin
            obs_access++;
            if (obs_access == waits + 1) begin
                pready = 1'b1; prdata = rd; pslverr = se;
            end else begin
                pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom_range(0, 1));
            end
            if (paddr !== obs_paddr || pwdata !== obs_pwdata || pstrb !== obs_pstrb)
                obs_stable = 1'b0;
            tick();
        end
        pready = 1'b0; prdata = $urandom; pslverr = 1'b0;
        obs_psel_at_rsp = psel; obs_rsp_valid = rsp_valid;
        obs_rdata = rsp_rdata; obs_err = rsp_err; obs_cmd_ready_rsp = cmd_ready;
        obs_hold_stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_rdata !== obs_rdata || rsp_err !== obs_err || cmd_ready !== 1'b0)
                obs_hold_stable = 1'b0;
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        obs_done_ok = (rsp_valid === 1'b0 && cmd_ready === 1'b1);
    endtask

    task automatic test_reset();
        prest = 1'b1;
        repeat (3) tick();
        n_vec++;
        if ({psel, penable, pwrite, rsp_valid, rsp_err} !== 5'b0) begin
            n_err++; $display("FAIL reset_ctrl: got %b want 00000", {psel, penable, pwrite, rsp_valid, rsp_err});
        end
        n_vec++;
        if ({paddr, pwdata, pstrb, rsp_rdata} !== 100'b0) begin
            n_err++; $display("FAIL reset_data: got %h want 0", {paddr, pwdata, pstrb, rsp_rdata});
        end
        n_vec++;
        if (cmd_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_cmd_ready_in_reset: got %b want 0", cmd_ready);
        end
        prest = 1'b0;
        #1;
        n_vec++;
        if (cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_cmd_ready_after: got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_write_zero_wait();
        run_xfer(1'b1, 32'h40, 32'hA5A5_0001, 4'hF, 0, 32'hDEAD_BEEF, 1'b0, 0);
        n_vec++;
        if (!obs_accept_ok || !obs_setup_ok) begin
            n_err++; $display("FAIL wr_setup: got accept=%b setup=%b want 1 1", obs_accept_ok, obs_setup_ok);
        end
        n_vec++;
        if ({obs_paddr, obs_pwdata, obs_pstrb, obs_pwrite} !== {32'h40, 32'hA5A5_0001, 4'hF, 1'b1}) begin
            n_err++; $display("FAIL wr_apb_fields: got %h %h %h %b want 40 a5a50001 f 1", obs_paddr, obs_pwdata, obs_pstrb, obs_pwrite);
        end
        n_vec++;
        if (obs_access != 1) begin
            n_err++; $display("FAIL wr_access_len: got %0d want 1", obs_access);
        end
        n_vec++;
        if ({obs_rsp_valid, obs_err, obs_rdata} !== {1'b1, 1'b0, 32'h0}) begin
            n_err++; $display("FAIL wr_rsp: got v=%b e=%b d=%h want 1 0 0", obs_rsp_valid, obs_err, obs_rdata);
        end
        n_vec++;
        if (!obs_done_ok) begin
            n_err++; $display("FAIL wr_done: got 0 want 1");
        end
    endtask

    task automatic test_read_wait();
        run_xfer(1'b0, 32'h44, 32'h5555_AAAA, 4'hF, 3, 32'h1234_5678, 1'b0, 0);
        n_vec++;
        if (obs_access != 4) begin
            n_err++; $display("FAIL rd_access_len: got %0d want 4", obs_access);
        end
        n_vec++;
        if ({obs_pwrite, obs_pstrb, obs_paddr} !== {1'b0, 4'h0, 32'h44}) begin
            n_err++; $display("FAIL rd_apb_fields: got %b %h %h want 0 0 44", obs_pwrite, obs_pstrb, obs_paddr);
        end
        n_vec++;
        if ({obs_err, obs_rdata} !== {1'b0, 32'h1234_5678}) begin
            n_err++; $display("FAIL rd_rsp: got e=%b d=%h want 0 12345678", obs_err, obs_rdata);
        end
    endtask

    task automatic test_slverr();
        run_xfer(1'b1, 32'h48, $urandom, 4'h3, $urandom_range(0, 3), 32'hFFFF_FFFF, 1'b1, 0);
        n_vec++;
        if ({obs_err, obs_rdata} !== {1'b1, 32'h0}) begin
            n_err++; $display("FAIL slverr_rsp: got e=%b d=%h want 1 0", obs_err, obs_rdata);
        end
        run_xfer(1'b0, 32'h4C, 32'h0, 4'h0, 1, 32'hCAFE_F00D, 1'b0, 0);
        n_vec++;
        if (!obs_accept_ok || {obs_err, obs_rdata} !== {1'b0, 32'hCAFE_F00D}) begin
            n_err++; $display("FAIL slverr_next: got acc=%b e=%b d=%h want 1 0 cafef00d", obs_accept_ok, obs_err, obs_rdata);
        end
    endtask

    task automatic test_timeout();
        run_xfer(1'b0, 32'h50, 32'h0, 4'h0, 1000, 32'h1111_1111, 1'b0, 0);
        n_vec++;
        if (obs_access != TO) begin
            n_err++; $display("FAIL to_access_len: got %0d want %0d", obs_access, TO);
        end
        n_vec++;
        if ({obs_rsp_valid, obs_psel_at_rsp, obs_err, obs_rdata} !== {1'b1, 1'b0, 1'b1, 32'h0}) begin
            n_err++; $display("FAIL to_rsp: got v=%b psel=%b e=%b d=%h want 1 0 1 0", obs_rsp_valid, obs_psel_at_rsp, obs_err, obs_rdata);
        end
        // pready on the last allowed cycle beats the timeout
        run_xfer(1'b0, 32'h54, 32'h0, 4'h0, TO - 1, 32'h7777_0007, 1'b0, 0);
        n_vec++;
        if (obs_access != TO || {obs_err, obs_rdata} !== {1'b0, 32'h7777_0007}) begin
            n_err++; $display("FAIL to_edge_pready_wins: got len=%0d e=%b d=%h want %0d 0 77770007", obs_access, obs_err, obs_rdata, TO);
        end
    endtask

    task automatic test_backpressure();
        run_xfer(1'b0, 32'h58, 32'h0, 4'h0, 0, 32'hABCD_0123, 1'b0, 5);
        n_vec++;
        if (!obs_hold_stable || obs_cmd_ready_rsp !== 1'b0) begin
            n_err++; $display("FAIL bp_hold: got stable=%b cmd_ready=%b want 1 0", obs_hold_stable, obs_cmd_ready_rsp);
        end
        n_vec++;
        if (obs_rdata !== 32'hABCD_0123 || !obs_done_ok) begin
            n_err++; $display("FAIL bp_rsp: got d=%h done=%b want abcd0123 1", obs_rdata, obs_done_ok);
        end
    endtask

    task automatic test_back_to_back();
        int first;
        run_xfer(1'b1, 32'h60, 32'h1, 4'h1, 0, 32'h0, 1'b0, 0);
        first = obs_accept_cyc;
        run_xfer(1'b1, 32'h64, 32'h2, 4'h2, 0, 32'h0, 1'b0, 0);
        n_vec++;
        if (obs_accept_cyc - first != 4) begin
            n_err++; $display("FAIL b2b_spacing: got %0d want 4", obs_accept_cyc - first);
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        cmd_write = 1'b1; cmd_addr = 32'h70; cmd_wdata = 32'h9; cmd_strb = 4'hF; cmd_valid = 1'b1;
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        tick();
        cmd_valid = 1'b0;
        tick();
        n_vec++;
        if (penable !== 1'b1) begin
            n_err++; $display("FAIL rstmid_in_access: got %b want 1", penable);
        end
        prest = 1'b1;
        tick();
        n_vec++;
        if ({psel, penable, rsp_valid, paddr} !== {3'b0, 32'h0}) begin
            n_err++; $display("FAIL rstmid_outputs: got %b%b%b %h want 000 0", psel, penable, rsp_valid, paddr);
        end
        prest = 1'b0;
        #1;
        n_vec++;
        if (cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL rstmid_cmd_ready: got %b want 1", cmd_ready);
        end
        run_xfer(1'b0, 32'h74, 32'h0, 4'h0, 0, 32'h0BAD_CAFE, 1'b0, 0);
        n_vec++;
        if ({obs_err, obs_rdata} !== {1'b0, 32'h0BAD_CAFE}) begin
            n_err++; $display("FAIL rstmid_recover: got e=%b d=%h want 0 0badcafe", obs_err, obs_rdata);
        end
    endtask

    task automatic test_random();
        logic        w, se;
        logic [31:0] a, wd, rd, erd;
        logic [3:0]  s;
        logic        eerr;
        int          waits, hold, eacc;
        for (int i = 0; i < 30; i++) begin
            w = 1'($urandom_range(0, 1)); se = 1'($urandom_range(0, 1));
            a = {$urandom, 2'b00}; wd = $urandom; rd = $urandom;
            s = 4'($urandom_range(0, 15));
            waits = $urandom_range(0, TO + 2);
            hold = $urandom_range(0, 3);
            model(w, waits, rd, se, eacc, erd, eerr);
            run_xfer(w, a, wd, s, waits, rd, se, hold);
            n_vec++;
            if (!obs_accept_ok || !obs_setup_ok || !obs_stable) begin
                n_err++; $display("FAIL rnd%0d_proto: got acc=%b setup=%b stable=%b want 1 1 1", i, obs_accept_ok, obs_setup_ok, obs_stable);
            end
            n_vec++;
            if ({obs_paddr, obs_pwdata, obs_pwrite, obs_pstrb} !== {a, wd, w, (w ? s : 4'h0)}) begin
                n_err++; $display("FAIL rnd%0d_fields: got %h %h %b %h want %h %h %b %h", i, obs_paddr, obs_pwdata, obs_pwrite, obs_pstrb, a, wd, w, (w ? s : 4'h0));
            end
            n_vec++;
            if (obs_access != eacc) begin
                n_err++; $display("FAIL rnd%0d_access_len: got %0d want %0d", i, obs_access, eacc);
            end
            n_vec++;
            if ({obs_rsp_valid, obs_psel_at_rsp, obs_err, obs_rdata} !== {1'b1, 1'b0, eerr, erd}) begin
                n_err++; $display("FAIL rnd%0d_rsp: got v=%b psel=%b e=%b d=%h want 1 0 %b %h", i, obs_rsp_valid, obs_psel_at_rsp, obs_err, obs_rdata, eerr, erd);
            end
            n_vec++;
            if (!obs_hold_stable || !obs_done_ok) begin
                n_err++; $display("FAIL rnd%0d_release: got hold=%b done=%b want 1 1", i, obs_hold_stable, obs_done_ok);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_slverr();
        test_timeout();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
